// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared types and encodings for the LSU AXI4-Lite initiator.
// Holds the FSM state enum, access-size codes, bus response code and the byte-lane mask helper.
package ysyx_25030093_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Unshifted byte-lane mask for an access size.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001;
            SIZE_H:  mask = 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// Byte-lane alignment for the LSU: store data/strobe placement, load extraction and extension,
// and the misaligned / illegal-size check.
module ysyx_25030093_lsu_align
    import ysyx_25030093_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_rdata,
    output logic        misalign
);

    logic [31:0] ld_shift_s;
    logic        sign_b_s;
    logic        sign_h_s;

    assign st_wdata   = st_data << {addr_lo, 3'b000};
    assign ld_shift_s = ld_data >> {addr_lo, 3'b000};
    assign sign_b_s   = ~is_unsigned & ld_shift_s[7];
    assign sign_h_s   = ~is_unsigned & ld_shift_s[15];

    // Write strobe: size mask moved up to the addressed lane.
    always_comb begin
        st_wstrb = 4'b0000;
        case (size)
            SIZE_B:  st_wstrb = size_mask(size) << addr_lo;
            SIZE_H:  st_wstrb = size_mask(size) << addr_lo;
            SIZE_W:  st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    // Load data: pick the lane, then sign- or zero-extend to a full word.
    always_comb begin
        ld_rdata = 32'h0000_0000;
        case (size)
            SIZE_B:  ld_rdata = {{24{sign_b_s}}, ld_shift_s[7:0]};
            SIZE_H:  ld_rdata = {{16{sign_h_s}}, ld_shift_s[15:0]};
            SIZE_W:  ld_rdata = ld_data;
            default: ld_rdata = 32'h0000_0000;
        endcase
    end

    // Illegal size is folded into the misalign flag so one error path covers both.
    always_comb begin
        misalign = 1'b0;
        case (size)
            SIZE_B:  misalign = 1'b0;
            SIZE_H:  misalign = addr_lo[0];
            SIZE_W:  misalign = |addr_lo;
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_lsu_axi_master.sv
// LSU AXI4-Lite initiator: takes one load/store from the EXU, runs AR/R or AW/W/B
// against the SRAM responder and returns a single response. One transaction in flight.
module ysyx_25030093_lsu_axi_master
    import ysyx_25030093_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    lsu_state_e  state_r;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic        aw_done_r;
    logic        w_done_r;

    logic [1:0]  sel_addr_lo_s;
    logic [1:0]  sel_size_s;
    logic        sel_unsigned_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_wstrb_s;
    logic [31:0] ld_rdata_s;
    logic        misalign_s;
    logic        aw_fire_s;
    logic        w_fire_s;
    logic        aw_all_s;
    logic        w_all_s;

    assign req_ready = (state_r == ST_IDLE);
    assign aw_fire_s = awvalid & awready;
    assign w_fire_s  = wvalid & wready;
    assign aw_all_s  = aw_done_r | aw_fire_s;
    assign w_all_s   = w_done_r | w_fire_s;

    // The aligner sees the live request while idle and the latched access afterwards.
    always_comb begin
        sel_addr_lo_s  = addr_lo_r;
        sel_size_s     = size_r;
        sel_unsigned_s = unsigned_r;
        if (state_r == ST_IDLE) begin
            sel_addr_lo_s  = req_addr[1:0];
            sel_size_s     = req_size;
            sel_unsigned_s = req_unsigned;
        end else begin
            sel_addr_lo_s  = addr_lo_r;
            sel_size_s     = size_r;
            sel_unsigned_s = unsigned_r;
        end
    end

    ysyx_25030093_lsu_align u_align (
        .addr_lo     (sel_addr_lo_s),
        .size        (sel_size_s),
        .is_unsigned (sel_unsigned_s),
        .st_data     (req_wdata[31:0]),
        .st_wdata    (st_wdata_s),
        .st_wstrb    (st_wstrb_s),
        .ld_data     (rdata[31:0]),
        .ld_rdata    (ld_rdata_s),
        .misalign    (misalign_s)
    );

    // Transaction FSM; every bus and response output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_lo_r  <= 2'b00;
            size_r     <= SIZE_B;
            unsigned_r <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            wstrb      <= 4'b0000;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_lo_r  <= req_addr[1:0];
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        if (misalign_s) begin
                            state_r    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_wen) begin
                            state_r   <= ST_WR;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            awaddr    <= req_addr;
                            wdata     <= st_wdata_s;
                            wstrb     <= st_wstrb_s;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_AR;
                            arvalid <= 1'b1;
                            araddr  <= req_addr;
                        end
                    end
                end
                ST_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid && rready) begin
                        rready     <= 1'b0;
                        resp_rdata <= ld_rdata_s;
                        resp_err   <= (rresp != RESP_OKAY);
                        resp_valid <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_WR: begin
                    if (aw_fire_s) begin
                        awvalid <= 1'b0;
                    end
                    if (w_fire_s) begin
                        wvalid <= 1'b0;
                    end
                    // AW and W may finish in either order or together.
                    if (aw_all_s && w_all_s) begin
                        bready    <= 1'b1;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        state_r   <= ST_B;
                    end else begin
                        aw_done_r <= aw_all_s;
                        w_done_r  <= w_all_s;
                    end
                end
                ST_B: begin
                    if (bvalid && bready) begin
                        bready     <= 1'b0;
                        resp_err   <= (bresp != RESP_OKAY);
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    arvalid    <= 1'b0;
                    rready     <= 1'b0;
                    awvalid    <= 1'b0;
                    wvalid     <= 1'b0;
                    bready     <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_lsu_axi_master.sv
// Self-checking bench for the LSU AXI4-Lite initiator: a cycle-level responder with
// configurable latencies plus an arithmetic reference model of alignment and timing.
module tb_ysyx_25030093_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25030093_lsu_axi_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    function automatic logic [31:0] model_load(input logic [31:0] d, input int lo, input int sz, input bit uns);
        logic [31:0] v;
        v = d >> (8 * lo);
        if (sz == 0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input int sz, input int lo);
        logic [7:0] m;
        int nb;
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        m = ((8'd1 << nb) - 8'd1) << lo;
        return m[3:0];
    endfunction

    function automatic bit model_bad(input int sz, input int lo);
        return (sz == 3) || (sz == 1 && (lo % 2) != 0) || (sz == 2 && lo != 0);
    endfunction

    // One complete transaction with the bench acting as responder and EXU.
    task automatic do_txn(input logic wen, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [1:0] resp,
                          input int ar_lat, input int r_lat, input int aw_lat,
                          input int w_lat, input int b_lat, input int hold,
                          output logic [31:0] o_rdata, output logic o_err, output int o_lat,
                          output int o_hs_ar, output int o_hs_r, output int o_hs_aw,
                          output int o_hs_w, output int o_hs_b, output int o_bus,
                          output int o_viol, output logic [31:0] o_wdata,
                          output logic [3:0] o_wstrb, output logic o_timeout);
        int cyc, arw, rw, aww, ww, bw, rs;
        bit ar_d, r_d, aw_d, w_d, b_d, seen, done;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_wd = wd << (8 * int'(addr[1:0]));
        exp_st = model_strb(int'(sz), int'(addr[1:0]));
        o_rdata = 32'h0; o_err = 1'b0; o_lat = 0; o_hs_ar = 0; o_hs_r = 0; o_hs_aw = 0;
        o_hs_w = 0; o_hs_b = 0; o_bus = 0; o_viol = 0; o_wdata = 32'h0; o_wstrb = 4'h0;
        o_timeout = 1'b0;
        cyc = 0; arw = 0; rw = 0; aww = 0; ww = 0; bw = 0; rs = 0;
        ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; seen = 0; done = 0;
        @(negedge clk);
        resp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; awready = 1'b0;
        wready = 1'b0; bvalid = 1'b0;
        req_valid = 1'b1; req_wen = wen; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        if (req_ready !== 1'b1) o_viol++;
        @(posedge clk);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            req_addr = $urandom();
            req_wdata = $urandom();
            if (arvalid) begin
                o_bus++;
                if (ar_d || araddr !== addr) o_viol++;
                arready = (arw >= ar_lat);
                arw++;
                if (arready) begin o_hs_ar++; ar_d = 1; end
            end else arready = 1'b0;
            if (rready && !r_d) begin
                rvalid = (rw >= r_lat);
                rw++;
                rdata = rvalid ? rd : $urandom();
                rresp = rvalid ? resp : 2'($urandom_range(3, 0));
                if (rvalid) begin o_hs_r++; r_d = 1; end
            end else begin
                if (rready) o_viol++;
                rvalid = 1'b0; rdata = $urandom(); rresp = 2'($urandom_range(3, 0));
            end
            if (awvalid) begin
                o_bus++;
                if (aw_d || awaddr !== addr) o_viol++;
                awready = (aww >= aw_lat);
                aww++;
                if (awready) begin o_hs_aw++; aw_d = 1; end
            end else awready = 1'b0;
            if (wvalid) begin
                o_bus++;
                if (ww == 0) begin o_wdata = wdata; o_wstrb = wstrb; end
                if (w_d || wdata !== exp_wd || wstrb !== exp_st) o_viol++;
                wready = (ww >= w_lat);
                ww++;
                if (wready) begin o_hs_w++; w_d = 1; end
            end else wready = 1'b0;
            if (bready && !b_d) begin
                bvalid = (bw >= b_lat);
                bw++;
                bresp = bvalid ? resp : 2'($urandom_range(3, 0));
                if (bvalid) begin o_hs_b++; b_d = 1; end
            end else begin
                if (bready) o_viol++;
                bvalid = 1'b0; bresp = 2'($urandom_range(3, 0));
            end
            if (resp_valid) begin
                if (req_ready !== 1'b0) o_viol++;
                if (!seen) begin
                    seen = 1; o_lat = cyc; o_rdata = resp_rdata; o_err = resp_err;
                end else if (resp_rdata !== o_rdata || resp_err !== o_err) o_viol++;
                resp_ready = (rs >= hold);
                rs++;
                if (resp_ready) done = 1;
            end else resp_ready = 1'b0;
        end
        if (!done) o_timeout = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; rresp = 2'b00; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err} !== 7'b0) begin
            errors++; $display("FAIL reset_valids got=%b exp=0", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err});
        end
        checks++;
        if ({araddr, awaddr, wdata, wstrb, resp_rdata} !== 132'b0) begin
            errors++; $display("FAIL reset_data araddr=%h awaddr=%h wdata=%h wstrb=%h rdata=%h exp=0", araddr, awaddr, wdata, wstrb, resp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (rd_o !== 32'hDEAD_BEEF || er_o !== 1'b0) begin
            errors++; $display("FAIL word_load data=%h err=%b exp=deadbeef/0", rd_o, er_o);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL word_load_latency got=%0d exp=3", lat); end
        checks++;
        if (har != 1 || hr != 1 || viol != 0 || to_o !== 1'b0) begin
            errors++; $display("FAIL word_load_protocol ar=%0d r=%0d viol=%0d to=%b exp=1/1/0/0", har, hr, viol, to_o);
        end
    endtask

    task automatic test_byte_load;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'h8011_2233, 2'b00, 1, 2, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (rd_o !== 32'hFFFF_FF80 || er_o !== 1'b0 || viol != 0) begin
            errors++; $display("FAIL byte_load_signed data=%h err=%b viol=%0d exp=ffffff80/0/0", rd_o, er_o, viol);
        end
        do_txn(1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'h8011_2233, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (rd_o !== 32'h0000_0080 || er_o !== 1'b0) begin
            errors++; $display("FAIL byte_load_unsigned data=%h err=%b exp=00000080/0", rd_o, er_o);
        end
    endtask

    task automatic test_half_store;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 2'b00, 0, 0, 3, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (wd_o !== 32'hABCD_0000 || st_o !== 4'b1100) begin
            errors++; $display("FAIL half_store_lanes wdata=%h wstrb=%b exp=abcd0000/1100", wd_o, st_o);
        end
        checks++;
        if (hb != 1 || haw != 1 || hw != 1 || har != 0 || viol != 0) begin
            errors++; $display("FAIL half_store_protocol b=%0d aw=%0d w=%0d ar=%0d viol=%0d exp=1/1/1/0/0", hb, haw, hw, har, viol);
        end
        checks++;
        if (lat != 6 || er_o !== 1'b0 || rd_o !== 32'h0) begin
            errors++; $display("FAIL half_store_resp lat=%0d err=%b data=%h exp=6/0/0", lat, er_o, rd_o);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (er_o !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL misaligned_resp err=%b lat=%0d exp=1/1", er_o, lat);
        end
        checks++;
        if (bus != 0 || viol != 0) begin
            errors++; $display("FAIL misaligned_no_bus bus_cycles=%0d viol=%0d exp=0/0", bus, viol);
        end
    endtask

    task automatic test_store_err_hold;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 2'b10, 0, 0, 0, 0, 1, 5,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (er_o !== 1'b1 || rd_o !== 32'h0) begin
            errors++; $display("FAIL store_bresp_err err=%b data=%h exp=1/0", er_o, rd_o);
        end
        checks++;
        if (viol != 0 || to_o !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL store_hold viol=%0d to=%b lat=%0d exp=0/0/4", viol, to_o, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010; arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL reset_mid_reach_r rready=%b exp=1", rready); end
        arready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 6'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_async valids=%b req_ready=%b exp=0/1", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 2'b01, 1'b1, 32'h8000_0012, 32'h0, 32'hF00D_1234, 2'b00, 0, 1, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (rd_o !== 32'h0000_F00D || er_o !== 1'b0 || viol != 0 || lat != 4) begin
            errors++; $display("FAIL reset_mid_recover data=%h err=%b viol=%0d lat=%0d exp=0000f00d/0/0/4", rd_o, er_o, viol, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd_o, wd_o, addr, wd, rd, exp_rd; logic er_o, to_o; logic [3:0] st_o;
        logic [1:0] sz, resp; logic wen, uns; bit bad, exp_err;
        int lat, har, hr, haw, hw, hb, bus, viol, al, rl, awl, wl, bl, hold, exp_lat, lo;
        for (int n = 0; n < 60; n++) begin
            wen = 1'($urandom_range(1, 0)); uns = 1'($urandom_range(1, 0));
            sz = 2'($urandom_range(3, 0));
            addr = 32'h8000_0000 | ($urandom() & 32'h0000_0FFF);
            wd = $urandom(); rd = $urandom();
            resp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            al = $urandom_range(3, 0); rl = $urandom_range(3, 0); awl = $urandom_range(3, 0);
            wl = $urandom_range(3, 0); bl = $urandom_range(3, 0); hold = $urandom_range(2, 0);
            do_txn(wen, sz, uns, addr, wd, rd, resp, al, rl, awl, wl, bl, hold,
                   rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
            lo = int'(addr[1:0]);
            bad = model_bad(int'(sz), lo);
            exp_err = bad || (resp != 2'b00);
            exp_rd = wen ? 32'h0 : model_load(rd, lo, int'(sz), uns);
            exp_lat = bad ? 1 : wen ? 3 + ((awl > wl) ? awl : wl) + bl : 3 + al + rl;
            checks++;
            if (er_o !== exp_err || to_o !== 1'b0) begin
                errors++; $display("FAIL rand_err[%0d] err=%b to=%b exp=%b/0", n, er_o, to_o, exp_err);
            end
            if (!bad) begin
                checks++;
                if (rd_o !== exp_rd) begin
                    errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, rd_o, exp_rd);
                end
            end
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, lat, exp_lat); end
            checks++;
            if (viol != 0 || har != int'(!bad && !wen) || hr != int'(!bad && !wen) ||
                haw != int'(!bad && wen) || hw != int'(!bad && wen) || hb != int'(!bad && wen)) begin
                errors++; $display("FAIL rand_protocol[%0d] viol=%0d ar=%0d r=%0d aw=%0d w=%0d b=%0d", n, viol, har, hr, haw, hw, hb);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd_o, wd_o; logic er_o, to_o; logic [3:0] st_o;
        int lat, har, hr, haw, hw, hb, bus, viol;
        do_txn(1'b1, 2'b00, 1'b0, 32'h8000_0021, 32'h0000_00A5, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (wd_o !== 32'h0000_A500 || st_o !== 4'b0010 || lat != 3 || viol != 0) begin
            errors++; $display("FAIL b2b_store wdata=%h wstrb=%b lat=%0d viol=%0d exp=0000a500/0010/3/0", wd_o, st_o, lat, viol);
        end
        do_txn(1'b0, 2'b01, 1'b0, 32'h8000_0022, 32'h0, 32'h9ABC_0000, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (rd_o !== 32'hFFFF_9ABC || lat != 3 || viol != 0) begin
            errors++; $display("FAIL b2b_load data=%h lat=%0d viol=%0d exp=ffff9abc/3/0", rd_o, lat, viol);
        end
        do_txn(1'b0, 2'b11, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0,
               rd_o, er_o, lat, har, hr, haw, hw, hb, bus, viol, wd_o, st_o, to_o);
        checks++;
        if (er_o !== 1'b1 || bus != 0 || lat != 1) begin
            errors++; $display("FAIL b2b_bad_size err=%b bus=%0d lat=%0d exp=1/0/1", er_o, bus, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_store_err_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
